// File: rtl/branch_predict_ctrl.sv
// Branch direction/target predictor and misprediction controller.
// Fetch side: combinational lookup in a direct-mapped BHT/BTB.
// Execute side: the resolved outcome is compared with the prediction carried down the pipe.
// A mismatch redirects the PC and flushes F/D and D/X in the same cycle.
// The table is trained, and branch/mispredict statistics are kept.
//
// Handshake: resolveValid is a qualifier with no ready/backpressure.
// A branch is consumed on the single rising edge where resolveValid=1, stall=0 and the FSM is in RUN.
// The block cannot refuse a branch; the upstream hazard unit holds it with stall instead.
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [PC_W-1:0]  pcF,
  output logic             predTakenF,
  output logic [PC_W-1:0]  predTargetF,
  input  logic             resolveValid,
  input  logic             resolveTaken,
  input  logic [PC_W-1:0]  resolveTarget,
  input  logic [PC_W-1:0]  pcDX,
  input  logic             predTakenDX,
  input  logic [PC_W-1:0]  predTargetDX,
  output logic             redirect,
  output logic [PC_W-1:0]  redirectPC,
  output logic             flushFD,
  output logic             flushDX,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredCount,
  output logic             fsm_state_dbg
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SHADOW = 1'b1;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             valid_q  [N];
  logic             valid_d  [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [TAG_W-1:0] tag_d    [N];
  logic [PC_W-1:0]  target_q [N];
  logic [PC_W-1:0]  target_d [N];
  logic [1:0]       ctr_q    [N];
  logic [1:0]       ctr_d    [N];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_x;
  logic [TAG_W-1:0] tag_f, tag_x;
  logic             hit_f, hit_x;
  logic             act, mispred;

  assign idx_f = pcF[IDX_W-1:0];
  assign tag_f = pcF[PC_W-1:IDX_W];
  assign idx_x = pcDX[IDX_W-1:0];
  assign tag_x = pcDX[PC_W-1:IDX_W];

  // Fetch-side prediction reads registered table contents, so a same-index write this cycle is not seen yet
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    predTakenF  = hit_f && ctr_q[idx_f][1];
    predTargetF = predTakenF ? target_q[idx_f] : pcF + PC_ONE;
  end

  // Resolution: act is gated by reset so an asserted reset masks redirect immediately
  always_comb begin
    hit_x      = valid_q[idx_x] && (tag_q[idx_x] == tag_x);
    act        = resolveValid && !stall && (state_q == ST_RUN) && !reset;
    mispred    = act && ((resolveTaken != predTakenDX) ||
                         (resolveTaken && (predTargetDX != resolveTarget)));
    redirect   = mispred;
    flushFD    = mispred;
    flushDX    = mispred;
    redirectPC = '0;
    if (mispred) begin
      redirectPC = resolveTaken ? resolveTarget : pcDX + PC_ONE;
    end
  end

  // Table training at the D/X index
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (act) begin
      if (resolveTaken) begin
        if (hit_x) begin
          if (ctr_q[idx_x] != 2'b11) ctr_d[idx_x] = ctr_q[idx_x] + 2'b01;
          target_d[idx_x] = resolveTarget;
        end else begin
          valid_d[idx_x]  = 1'b1;
          tag_d[idx_x]    = tag_x;
          target_d[idx_x] = resolveTarget;
          ctr_d[idx_x]    = 2'b10;
        end
      end else if (hit_x) begin
        if (ctr_q[idx_x] != 2'b00) ctr_d[idx_x] = ctr_q[idx_x] - 2'b01;
      end
    end
  end

  // FSM and saturating statistics; SHADOW lasts one cycle to skip the squashed wrong-path branch
  always_comb begin
    state_d       = (state_q == ST_RUN && mispred) ? ST_SHADOW : ST_RUN;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (act && branch_cnt_q != CNT_MAX)      branch_cnt_d  = branch_cnt_q + CNT_ONE;
    if (mispred && mispred_cnt_q != CNT_MAX) mispred_cnt_d = mispred_cnt_q + CNT_ONE;
  end

  assign branchCount   = branch_cnt_q;
  assign mispredCount  = mispred_cnt_q;
  assign fsm_state_dbg = state_q;

  // State registers with asynchronous reset; the table is cleared to invalid/weakly-not-taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      state_q       <= ST_RUN;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      state_q       <= state_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed plan steps followed by random traffic.
// All expectations come from a behavioural predictor model kept in this file.
module tb_branch_predict_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pcF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        resolveValid;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic [31:0] pcDX;
  logic        predTakenDX;
  logic [31:0] predTargetDX;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        flushFD;
  logic        flushDX;
  logic [15:0] branchCount;
  logic [15:0] mispredCount;
  logic        fsm_state_dbg;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: one record per table slot, plus a "skip next resolution" flag
  bit          m_valid  [16];
  logic [27:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  bit          m_skip;
  int          m_bc, m_mc;
  bit          e_act, e_mis;

  branch_predict_ctrl #(.IDX_W(4), .PC_W(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .stall(stall), .pcF(pcF),
    .predTakenF(predTakenF), .predTargetF(predTargetF),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken),
    .resolveTarget(resolveTarget), .pcDX(pcDX), .predTakenDX(predTakenDX),
    .predTargetDX(predTargetDX), .redirect(redirect), .redirectPC(redirectPC),
    .flushFD(flushFD), .flushDX(flushDX), .branchCount(branchCount),
    .mispredCount(mispredCount), .fsm_state_dbg(fsm_state_dbg)
  );

  // clock
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_skip = 0; m_bc = 0; m_mc = 0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'(pc % 16);
    return m_valid[i] && (m_tag[i] == pc[31:4]);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[int'(pc % 16)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[int'(pc % 16)] : pc + 32'd1;
  endfunction

  // mid-cycle: compare every output against the model for the current inputs
  task automatic settle();
    logic [31:0] e_rpc;
    @(negedge clock);
    e_act = resolveValid && !stall && !m_skip;
    e_mis = e_act && ((resolveTaken != predTakenDX) ||
                      (resolveTaken && predTargetDX != resolveTarget));
    e_rpc = !e_mis ? 32'd0 : (resolveTaken ? resolveTarget : pcDX + 32'd1);
    chk("predTakenF",  {31'd0, predTakenF}, {31'd0, m_pred(pcF)});
    chk("predTargetF", predTargetF, m_ptgt(pcF));
    chk("redirect",    {31'd0, redirect}, {31'd0, e_mis});
    chk("flushFD",     {31'd0, flushFD},  {31'd0, e_mis});
    chk("flushDX",     {31'd0, flushDX},  {31'd0, e_mis});
    chk("redirectPC",  redirectPC, e_rpc);
    chk("branchCount", {16'd0, branchCount},  m_bc);
    chk("mispredCount",{16'd0, mispredCount}, m_mc);
  endtask

  // clock edge: apply the training rules, then return to posedge+1
  task automatic tick();
    int i;
    i = int'(pcDX % 16);
    if (e_act) begin
      if (resolveTaken) begin
        if (m_hit(pcDX)) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = resolveTarget;
        end else begin
          m_valid[i] = 1; m_tag[i] = pcDX[31:4]; m_target[i] = resolveTarget; m_ctr[i] = 2;
        end
      end else if (m_hit(pcDX)) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
      if (m_bc < 65535) m_bc++;
    end
    if (e_mis && m_mc < 65535) m_mc++;
    m_skip = e_mis;
    @(posedge clock);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
    resolveValid = 1; pcDX = pc; resolveTaken = tk; resolveTarget = tgt;
    predTakenDX = ptk; predTargetDX = ptgt;
  endtask

  task automatic idle();
    resolveValid = 0; resolveTaken = 0; stall = 0;
    settle(); tick();
  endtask

  initial begin
    bit tk;
    logic [31:0] pc;
    reset = 1; stall = 0; pcF = 32'h10; resolveValid = 0; resolveTaken = 0;
    resolveTarget = 0; pcDX = 0; predTakenDX = 0; predTargetDX = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // reset state
    settle();
    chk("rst_pred", {31'd0, predTakenF}, 32'd0);
    chk("rst_tgt", predTargetF, 32'h11);
    chk("rst_fsm", {31'd0, fsm_state_dbg}, 32'd0);
    tick();

    // first taken branch: allocate and mispredict
    resolve(32'h10, 1, 32'h40, 0, 32'h11);
    settle();
    chk("alloc_redir", {31'd0, redirect}, 32'd1);
    chk("alloc_rpc", redirectPC, 32'h40);
    tick();
    pcF = 32'h10;
    idle();
    settle();
    chk("alloc_pred", {31'd0, predTakenF}, 32'd1);
    chk("alloc_ptgt", predTargetF, 32'h40);
    chk("alloc_bc", {16'd0, branchCount}, 32'd1);
    chk("alloc_mc", {16'd0, mispredCount}, 32'd1);
    tick();

    // not-taken training and saturation at zero
    resolve(32'h10, 0, 32'h40, 1, 32'h40);
    settle();
    chk("nt1_rpc", redirectPC, 32'h11);
    tick();
    idle();
    resolve(32'h10, 0, 32'h40, 0, 32'h11);
    settle(); tick();
    resolve(32'h10, 0, 32'h40, 0, 32'h11);
    settle(); tick();
    resolve(32'h10, 1, 32'h40, 0, 32'h11);
    settle(); tick();
    idle();
    settle();
    chk("sat_pred", {31'd0, predTakenF}, 32'd0);
    tick();

    // shadow cycle after a mispredict
    resolve(32'h20, 1, 32'h50, 0, 32'h21);
    settle(); tick();
    settle();
    chk("shadow_redir", {31'd0, redirect}, 32'd0);
    chk("shadow_fsm", {31'd0, fsm_state_dbg}, 32'd1);
    tick();
    settle();
    chk("post_shadow_redir", {31'd0, redirect}, 32'd1);
    tick();
    idle();

    // stalled branch resolved exactly once
    pcF = 32'h30;
    resolve(32'h30, 1, 32'h60, 0, 32'h31);
    stall = 1;
    repeat (3) begin settle(); tick(); end
    stall = 0;
    settle();
    chk("stall_redir", {31'd0, redirect}, 32'd1);
    tick();
    idle();
    settle();
    chk("stall_pred", predTargetF, 32'h60);
    tick();

    // target change on a hit
    pcF = 32'h50;
    resolve(32'h50, 1, 32'h40, 0, 32'h51);
    settle(); tick();
    idle();
    resolve(32'h50, 1, 32'h80, 1, 32'h40);
    settle();
    chk("tgt_rpc", redirectPC, 32'h80);
    tick();
    idle();
    settle();
    chk("tgt_new", predTargetF, 32'h80);
    tick();

    // asynchronous reset in mid-cycle with a mispredicting branch on the inputs
    resolve(32'h50, 0, 32'h80, 1, 32'h80);
    #2 reset = 1;
    model_reset();
    #1;
    chk("arst_pred", {31'd0, predTakenF}, 32'd0);
    chk("arst_ptgt", predTargetF, 32'h51);
    chk("arst_redir", {31'd0, redirect}, 32'd0);
    chk("arst_bc", {16'd0, branchCount}, 32'd0);
    chk("arst_mc", {16'd0, mispredCount}, 32'd0);
    @(posedge clock);
    #1 reset = 0;
    idle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      pcF = $urandom_range(0, 63);
      pc  = $urandom_range(0, 63);
      tk  = $urandom_range(0, 1);
      resolveValid = ($urandom_range(0, 9) < 6);
      stall = ($urandom_range(0, 3) == 0);
      pcDX = pc; resolveTaken = tk;
      resolveTarget = $urandom_range(0, 7) * 16;
      if ($urandom_range(0, 3) != 0) begin
        predTakenDX = m_pred(pc); predTargetDX = m_ptgt(pc);
      end else begin
        predTakenDX = $urandom_range(0, 1); predTargetDX = $urandom_range(0, 127);
      end
      settle(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
